// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the program/data RAM arbiter: default bus widths,
// sequencer state encoding and requester identifiers.
package mem_arbiter_pkg;

  localparam int AW_DEF = 13;
  localparam int DW_DEF = 8;

  // Sequencer states (2-bit encoding kept stable for legacy compatibility)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_ACK    = 2'd3;

  // Requester identifiers, also the value presented on GNT
  localparam logic REQ_CPU    = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request always wins, a tie goes to the
// requester that was not served last.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] REQ,
  input  logic       LAST,
  output logic       VALID,
  output logic       WINNER
);

  // Pick a winner from the current request vector and the last owner
  always_comb begin
    VALID  = |REQ;
    WINNER = REQ_CPU;
    if (REQ == 2'b11) begin
      WINNER = ~LAST;
    end else if (REQ[1]) begin
      WINNER = REQ_LOADER;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and fixed-timing access sequencer for the shared asynchronous RAM.
// One requester is granted in IDLE, its request is latched, and the RAM is
// driven through SETUP -> STROBE (WAIT_CYCLES) -> ACK before returning to IDLE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          C_REQ,
  input  logic          C_WE,
  input  logic [AW-1:0] C_ADDR,
  input  logic [DW-1:0] C_WDATA,
  output logic          C_ACK,
  input  logic          L_REQ,
  input  logic          L_WE,
  input  logic [AW-1:0] L_ADDR,
  input  logic [DW-1:0] L_WDATA,
  output logic          L_ACK,
  output logic [DW-1:0] RDATA,
  output logic          GNT,
  output logic          BUSY,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  output logic          MEM_DOE,
  output logic          MEM_RD,
  output logic          MEM_WR,
  input  logic [DW-1:0] MEM_RDATA
);

  // Counter value of the final strobe cycle
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  logic [1:0]    state_reg;
  logic [3:0]    cnt_reg;
  logic          last_reg;
  logic          gnt_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] rdata_reg;

  logic          pick_valid;
  logic          pick_winner;
  logic          strobe_last;

  rr_pick2 u_pick (
    .REQ    ({L_REQ, C_REQ}),
    .LAST   (last_reg),
    .VALID  (pick_valid),
    .WINNER (pick_winner)
  );

  assign strobe_last = (cnt_reg == CNT_LAST);

  // Sequencer state and strobe-length counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            state_reg <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt_reg   <= 4'd0;
          state_reg <= ST_STROBE;
        end
        ST_STROBE: begin
          if (strobe_last) begin
            state_reg <= ST_ACK;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Latch the winning request; it stays frozen for the whole access
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gnt_reg   <= REQ_CPU;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (state_reg == ST_IDLE && pick_valid) begin
      gnt_reg   <= pick_winner;
      we_reg    <= pick_winner ? L_WE    : C_WE;
      addr_reg  <= pick_winner ? L_ADDR  : C_ADDR;
      wdata_reg <= pick_winner ? L_WDATA : C_WDATA;
    end
  end

  // Read data capture at the end of the last strobe cycle; LAST updates in ACK
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rdata_reg <= '0;
      last_reg  <= REQ_LOADER;
    end else begin
      if (state_reg == ST_STROBE && strobe_last && !we_reg) begin
        rdata_reg <= MEM_RDATA;
      end
      if (state_reg == ST_ACK) begin
        last_reg <= gnt_reg;
      end
    end
  end

  // Strobes, DOE and ACKs decode straight from state so reset clears them at once
  assign MEM_RD    = (state_reg == ST_STROBE) && !we_reg;
  assign MEM_WR    = (state_reg == ST_STROBE) &&  we_reg;
  assign MEM_DOE   = we_reg && ((state_reg == ST_SETUP) || (state_reg == ST_STROBE));
  assign C_ACK     = (state_reg == ST_ACK) && (gnt_reg == REQ_CPU);
  assign L_ACK     = (state_reg == ST_ACK) && (gnt_reg == REQ_LOADER);
  assign BUSY      = (state_reg != ST_IDLE);
  assign GNT       = gnt_reg;
  assign MEM_ADDR  = addr_reg;
  assign MEM_WDATA = wdata_reg;
  assign RDATA     = rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance with WAIT_CYCLES = 1 on a RAM model,
// a second with WAIT_CYCLES = 4 driven from a bench-controlled read bus.
module tb_mem_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;

  typedef struct {
    bit            id;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance with WAIT_CYCLES = 1
  logic          c_req = 0, c_we = 0, l_req = 0, l_we = 0;
  logic [AW-1:0] c_addr = '0, l_addr = '0;
  logic [DW-1:0] c_wdata = '0, l_wdata = '0;
  logic          c_ack, l_ack, gnt, busy, mem_doe, mem_rd, mem_wr;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] ram [0:(1<<AW)-1];

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_wr) ram[mem_addr] <= mem_wdata;

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(1)) dut (
    .CLK(clk), .RST(rst_n),
    .C_REQ(c_req), .C_WE(c_we), .C_ADDR(c_addr), .C_WDATA(c_wdata), .C_ACK(c_ack),
    .L_REQ(l_req), .L_WE(l_we), .L_ADDR(l_addr), .L_WDATA(l_wdata), .L_ACK(l_ack),
    .RDATA(rdata), .GNT(gnt), .BUSY(busy),
    .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_DOE(mem_doe),
    .MEM_RD(mem_rd), .MEM_WR(mem_wr), .MEM_RDATA(mem_rdata)
  );

  // Instance with WAIT_CYCLES = 4
  logic          c_req4 = 0, c_we4 = 0, l_req4 = 0, l_we4 = 0;
  logic [AW-1:0] c_addr4 = '0, l_addr4 = '0;
  logic [DW-1:0] c_wdata4 = '0, l_wdata4 = '0, mem_rdata4 = '0;
  logic          c_ack4, l_ack4, gnt4, busy4, mem_doe4, mem_rd4, mem_wr4;
  logic [DW-1:0] rdata4, mem_wdata4;
  logic [AW-1:0] mem_addr4;

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(4)) dut4 (
    .CLK(clk), .RST(rst_n),
    .C_REQ(c_req4), .C_WE(c_we4), .C_ADDR(c_addr4), .C_WDATA(c_wdata4), .C_ACK(c_ack4),
    .L_REQ(l_req4), .L_WE(l_we4), .L_ADDR(l_addr4), .L_WDATA(l_wdata4), .L_ACK(l_ack4),
    .RDATA(rdata4), .GNT(gnt4), .BUSY(busy4),
    .MEM_ADDR(mem_addr4), .MEM_WDATA(mem_wdata4), .MEM_DOE(mem_doe4),
    .MEM_RD(mem_rd4), .MEM_WR(mem_wr4), .MEM_RDATA(mem_rdata4)
  );

  task automatic test_reset();
    logic [31:0] got;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    got = {busy, gnt, c_ack, l_ack, mem_rd, mem_wr, mem_doe, busy4, c_ack4, l_ack4, mem_rd4, mem_wr4, mem_doe4};
    if (got !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %h expected 0", got);
    end
    vectors++;
    if (mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0 || rdata4 !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: got addr=%h wdata=%h rdata=%h rdata4=%h expected all 0", mem_addr, mem_wdata, rdata, rdata4);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_cpu_write();
    txn_t e;
    int   wr_cnt = 0, ack_cyc = 0;
    bit   bad_wr = 0, wrong_ack = 0;
    e = '{1'b0, 1'b1, 13'h0010, 8'hA5, 8'h00};
    c_req = 1; c_we = 1; c_addr = 13'h0010; c_wdata = 8'hA5;
    exp_q.push_back(e);
    for (int cyc = 1; cyc <= 10 && ack_cyc == 0; cyc++) begin
      @(negedge clk);
      if (mem_wr) begin
        wr_cnt++;
        if (mem_addr !== 13'h0010 || mem_wdata !== 8'hA5 || mem_doe !== 1'b1 || mem_rd !== 1'b0) bad_wr = 1;
      end
      if (l_ack) wrong_ack = 1;
      if (c_ack) begin
        ack_cyc = cyc;
        c_req = 0;
        $display("txn cpu write addr=%h data=%h ack_cycle=%0d", mem_addr, mem_wdata, cyc);
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL cpu_write_sb: got ack with empty scoreboard expected entry");
        end else begin
          e = exp_q.pop_front();
          if (e.id !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_write_sb: got id 0 expected %0d", e.id);
          end
        end
      end
    end
    vectors++;
    if (ack_cyc !== 3) begin
      miscompares++;
      $display("FAIL cpu_write_ack_cycle: got %0d expected 3", ack_cyc);
    end
    vectors++;
    if (wr_cnt !== 1 || bad_wr || wrong_ack) begin
      miscompares++;
      $display("FAIL cpu_write_strobe: got wr_cycles=%0d bad=%b wrong_ack=%b expected 1/0/0", wr_cnt, bad_wr, wrong_ack);
    end
    vectors++;
    if (ram[13'h0010] !== 8'hA5) begin
      miscompares++;
      $display("FAIL cpu_write_ram: got %h expected a5", ram[13'h0010]);
    end
  endtask

  task automatic test_loader_read();
    txn_t e;
    int   rd_cnt = 0, ack_cyc = 0;
    bit   doe_seen = 0, wrong_ack = 0;
    @(negedge clk);
    e = '{1'b1, 1'b0, 13'h0010, 8'h00, 8'hA5};
    l_req = 1; l_we = 0; l_addr = 13'h0010;
    exp_q.push_back(e);
    for (int cyc = 1; cyc <= 10 && ack_cyc == 0; cyc++) begin
      @(negedge clk);
      if (mem_rd) rd_cnt++;
      if (mem_doe || mem_wr) doe_seen = 1;
      if (c_ack) wrong_ack = 1;
      if (l_ack) begin
        ack_cyc = cyc;
        l_req = 0;
        $display("txn loader read addr=%h rdata=%h gnt=%b ack_cycle=%0d", mem_addr, rdata, gnt, cyc);
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL loader_read_sb: got ack with empty scoreboard expected entry");
        end else begin
          e = exp_q.pop_front();
          if (e.id !== 1'b1 || rdata !== e.rdata || gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL loader_read_data: got id=1 rdata=%h gnt=%b expected id=%0d rdata=%h gnt=1", rdata, gnt, e.id, e.rdata);
          end
        end
      end
    end
    vectors++;
    if (ack_cyc !== 3 || rd_cnt !== 1 || doe_seen || wrong_ack) begin
      miscompares++;
      $display("FAIL loader_read_timing: got ack=%0d rd=%0d doe=%b wrong=%b expected 3/1/0/0", ack_cyc, rd_cnt, doe_seen, wrong_ack);
    end
  endtask

  task automatic test_back_to_back();
    txn_t e;
    int   acks = 0, last_ack = -10, bad_period = 0, bad_gap = 0;
    bit   excl = 0;
    @(negedge clk);
    c_req = 1; c_we = 1; c_addr = 13'h0030; c_wdata = 8'h55;
    l_req = 1; l_we = 0; l_addr = 13'h0021;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) e = '{1'b0, 1'b1, 13'h0030, 8'h55, 8'h00};
      else            e = '{1'b1, 1'b0, 13'h0021, 8'h00, 8'hC3};
      exp_q.push_back(e);
    end
    for (int cyc = 1; cyc <= 60 && acks < 6; cyc++) begin
      @(negedge clk);
      if (mem_rd && (mem_wr || mem_doe)) excl = 1;
      if (cyc == last_ack + 1 && busy !== 1'b0) bad_gap++;
      if (cyc == last_ack + 2 && (busy !== 1'b1 || mem_rd || mem_wr)) bad_gap++;
      if (c_ack || l_ack) begin
        $display("txn back_to_back #%0d c_ack=%b l_ack=%b gnt=%b rdata=%h cycle=%0d", acks, c_ack, l_ack, gnt, rdata, cyc);
        if (acks > 0 && cyc - last_ack != 4) bad_period++;
        last_ack = cyc;
        acks++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_sb: got ack with empty scoreboard expected entry");
        end else begin
          e = exp_q.pop_front();
          if ((c_ack && l_ack) || l_ack !== e.id || gnt !== e.id || (!e.we && rdata !== e.rdata)) begin
            miscompares++;
            $display("FAIL b2b_grant: got c_ack=%b l_ack=%b gnt=%b rdata=%h expected id=%0d rdata=%h", c_ack, l_ack, gnt, rdata, e.id, e.rdata);
          end
        end
        if (acks == 6) begin c_req = 0; l_req = 0; end
      end
    end
    vectors++;
    if (acks !== 6 || bad_period !== 0 || bad_gap !== 0 || excl) begin
      miscompares++;
      $display("FAIL b2b_timing: got acks=%0d bad_period=%0d bad_gap=%0d excl=%b expected 6/0/0/0", acks, bad_period, bad_gap, excl);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || ram[13'h0030] !== 8'h55) begin
      miscompares++;
      $display("FAIL b2b_end: got busy=%b ram=%h expected 0/55", busy, ram[13'h0030]);
    end
  endtask

  task automatic test_wait4();
    txn_t e;
    int   rd_cnt = 0, ack_cyc = 0;
    bit   doe_seen = 0;
    @(negedge clk);
    e = '{1'b0, 1'b0, 13'h0005, 8'h00, 8'h9E};
    mem_rdata4 = 8'h11; c_req4 = 1; c_we4 = 0; c_addr4 = 13'h0005;
    exp_q.push_back(e);
    for (int cyc = 1; cyc <= 14 && ack_cyc == 0; cyc++) begin
      @(negedge clk);
      if (mem_rd4) begin
        rd_cnt++;
        if (mem_addr4 !== 13'h0005) doe_seen = 1;
        // Final read data only appears for the edge ending the last strobe
        if (rd_cnt == 4) mem_rdata4 = 8'h9E;
      end
      if (mem_doe4 || mem_wr4 || l_ack4) doe_seen = 1;
      if (c_ack4) begin
        ack_cyc = cyc;
        c_req4 = 0;
        $display("txn wait4 cpu read addr=%h rdata=%h ack_cycle=%0d", mem_addr4, rdata4, cyc);
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL wait4_sb: got ack with empty scoreboard expected entry");
        end else begin
          e = exp_q.pop_front();
          if (rdata4 !== e.rdata) begin
            miscompares++;
            $display("FAIL wait4_rdata: got %h expected %h", rdata4, e.rdata);
          end
        end
      end
    end
    vectors++;
    if (ack_cyc !== 6 || rd_cnt !== 4 || doe_seen) begin
      miscompares++;
      $display("FAIL wait4_timing: got ack=%0d rd=%0d bad=%b expected 6/4/0", ack_cyc, rd_cnt, doe_seen);
    end
  endtask

  task automatic test_reset_mid();
    txn_t e;
    int   acks = 0, wr_seen = 0;
    bit   ack_in_reset = 0;
    // Complete a CPU access first so LAST points at the CPU before reset
    @(negedge clk);
    c_req = 1; c_we = 1; c_addr = 13'h0041; c_wdata = 8'h12;
    for (int cyc = 1; cyc <= 10 && acks == 0; cyc++) begin
      @(negedge clk);
      if (c_ack) begin acks = 1; c_req = 0; end
    end
    vectors++;
    if (acks !== 1) begin
      miscompares++;
      $display("FAIL reset_mid_pre: got acks=%0d expected 1", acks);
    end
    @(negedge clk);
    c_req = 1; c_we = 1; c_addr = 13'h0040; c_wdata = 8'h77;
    exp_q.push_back('{1'b0, 1'b1, 13'h0040, 8'h77, 8'h00});
    for (int cyc = 1; cyc <= 8 && wr_seen == 0; cyc++) begin
      @(negedge clk);
      if (mem_wr) wr_seen = cyc;
    end
    rst_n = 1'b0;
    c_req = 0;
    exp_q.delete();
    #1;
    vectors++;
    if (wr_seen !== 2 || mem_wr !== 1'b0 || mem_doe !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: got wr_cycle=%0d wr=%b doe=%b busy=%b expected 2/0/0/0", wr_seen, mem_wr, mem_doe, busy);
    end
    repeat (2) begin
      @(negedge clk);
      if (c_ack || l_ack || mem_wr) ack_in_reset = 1;
    end
    rst_n = 1'b1;
    // Tie after reset must go to the CPU first
    c_req = 1; c_we = 0; c_addr = 13'h0021;
    l_req = 1; l_we = 0; l_addr = 13'h0010;
    exp_q.push_back('{1'b0, 1'b0, 13'h0021, 8'h00, 8'hC3});
    exp_q.push_back('{1'b1, 1'b0, 13'h0010, 8'h00, 8'hA5});
    acks = 0;
    for (int cyc = 1; cyc <= 20 && acks < 2; cyc++) begin
      @(negedge clk);
      if (cyc <= 2 && (c_ack || l_ack)) ack_in_reset = 1;
      if (c_ack || l_ack) begin
        $display("txn post_reset c_ack=%b l_ack=%b rdata=%h cycle=%0d", c_ack, l_ack, rdata, cyc);
        acks++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL post_reset_sb: got ack with empty scoreboard expected entry");
        end else begin
          e = exp_q.pop_front();
          if (l_ack !== e.id || c_ack === l_ack || rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL post_reset_order: got l_ack=%b rdata=%h expected id=%0d rdata=%h", l_ack, rdata, e.id, e.rdata);
          end
        end
        if (c_ack) c_req = 0;
        if (l_ack) l_req = 0;
      end
    end
    vectors++;
    if (acks !== 2 || ack_in_reset) begin
      miscompares++;
      $display("FAIL reset_mid_acks: got acks=%0d spurious=%b expected 2/0", acks, ack_in_reset);
    end
    vectors++;
    if (ram[13'h0040] === 8'h77 && wr_seen == 0) begin
      miscompares++;
      $display("FAIL reset_mid_ram: got %h expected no write", ram[13'h0040]);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    ram[13'h0021] = 8'hC3;
    test_reset();
    test_cpu_write();
    test_loader_read();
    test_back_to_back();
    test_wait4();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
